// File: rtl/guard_fm_read_expand.sv
`default_nettype none
// guard_fm_read_expand: guard-masked FM byte reader that re-expands each group into a dense 6x8 vector.
// Optional 4-bit packed (no guard) mode is compiled in with FM_EXPAND_BITMODE_EN.
module guard_fm_read_expand #(
  parameter int GUARD_ADDR_W = 10,
  parameter int FM_ADDR_W    = 12,
  parameter int PACE_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ctrl_valid,
  output logic                    ctrl_ready,
  output logic                    ctrl_finish,
  input  logic [PACE_W-1:0]       pace_i,
  input  logic                    bit_mode_i,
  input  logic [GUARD_ADDR_W-1:0] guard_base_i,
  input  logic [FM_ADDR_W-1:0]    fm_base_i,
  output logic                    guard_rd_en,
  output logic [GUARD_ADDR_W-1:0] guard_addr_o,
  input  logic [5:0]              guard_i,
  output logic                    fm_rd_en,
  output logic [FM_ADDR_W-1:0]    fm_addr_o,
  input  logic [7:0]              fm_i,
  output logic [47:0]             data_o,
  output logic                    data_o_valid,
  input  logic                    data_o_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    G_RD    = 3'd1,
    G_DEC   = 3'd2,
    FM_RD   = 3'd3,
    B_RD    = 3'd4,
    FM_WAIT = 3'd5,
    EMIT    = 3'd6,
    FIN     = 3'd7
  } state_t;

  state_t                  state, next_state;
  logic [PACE_W-1:0]       pace;
  logic                    bit_mode;
  logic [GUARD_ADDR_W-1:0] guard_addr;
  logic [FM_ADDR_W-1:0]    fm_addr;
  logic [5:0]              pending;
  logic [5:0]              pending_clr;
  logic [2:0]              hi_lane;
  logic [1:0]              byte_cnt;
  logic                    tag_vld;
  logic [2:0]              tag_lane;
  logic [47:0]             data;
  logic                    mode_bm;

`ifdef FM_EXPAND_BITMODE_EN
  logic                    tag_bm;
  assign mode_bm = bit_mode_i;
`else
  logic                    unused_bit_mode;
  assign unused_bit_mode = bit_mode_i;
  assign mode_bm         = 1'b0;
`endif

  // Highest pending lane is fetched first; its bit is dropped once read.
  always_comb begin
    hi_lane = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (pending[i]) hi_lane = 3'(i);
    end
    pending_clr = pending & ~(6'b000001 << hi_lane);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ctrl_valid) begin
          if (pace_i == '0) next_state = FIN;
          else              next_state = mode_bm ? B_RD : G_RD;
        end
      end
      G_RD:    next_state = G_DEC;
      G_DEC:   next_state = (guard_i == 6'b000000) ? EMIT : FM_RD;
      FM_RD:   if (pending_clr == 6'b000000) next_state = FM_WAIT;
      B_RD:    if (byte_cnt == 2'd2) next_state = FM_WAIT;
      FM_WAIT: next_state = EMIT;
      EMIT: begin
        if (data_o_ready) begin
          if (pace == PACE_W'(1)) next_state = FIN;
          else                    next_state = bit_mode ? B_RD : G_RD;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ctrl_ready   = (state == IDLE);
  assign ctrl_finish  = (state == FIN);
  assign guard_rd_en  = (state == G_RD);
  assign fm_rd_en     = (state == FM_RD) || (state == B_RD);
  assign data_o_valid = (state == EMIT);
  assign data_o       = data;
  assign guard_addr_o = guard_addr;
  assign fm_addr_o    = fm_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pace       <= '0;
      bit_mode   <= 1'b0;
      guard_addr <= '0;
      fm_addr    <= '0;
      pending    <= '0;
      byte_cnt   <= '0;
      tag_vld    <= 1'b0;
      tag_lane   <= '0;
      data       <= '0;
`ifdef FM_EXPAND_BITMODE_EN
      tag_bm     <= 1'b0;
`endif
    end else begin
      tag_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_valid) begin
            pace       <= pace_i;
            bit_mode   <= mode_bm;
            guard_addr <= guard_base_i;
            fm_addr    <= fm_base_i;
            byte_cnt   <= '0;
          end
        end
        G_RD: begin
          guard_addr <= guard_addr + 1'b1;
          data       <= '0;
        end
        G_DEC: pending <= guard_i;
        FM_RD: begin
          fm_addr  <= fm_addr + 1'b1;
          pending  <= pending_clr;
          tag_vld  <= 1'b1;
          tag_lane <= hi_lane;
`ifdef FM_EXPAND_BITMODE_EN
          tag_bm   <= 1'b0;
`endif
        end
        B_RD: begin
          fm_addr  <= fm_addr + 1'b1;
          byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
          tag_vld  <= 1'b1;
          tag_lane <= {1'b0, byte_cnt};
`ifdef FM_EXPAND_BITMODE_EN
          tag_bm   <= 1'b1;
`endif
        end
        EMIT: if (data_o_ready) pace <= pace - 1'b1;
        default: ;
      endcase

      // Read data lands one cycle after its strobe, steered by the delayed lane tag.
      if (tag_vld) begin
`ifdef FM_EXPAND_BITMODE_EN
        if (tag_bm) begin
          case (tag_lane[1:0])
            2'd0:    data[47:32] <= {4'h0, fm_i[7:4], 4'h0, fm_i[3:0]};
            2'd1:    data[31:16] <= {4'h0, fm_i[7:4], 4'h0, fm_i[3:0]};
            default: data[15:0]  <= {4'h0, fm_i[7:4], 4'h0, fm_i[3:0]};
          endcase
        end else begin
          data[{tag_lane, 3'b000} +: 8] <= fm_i;
        end
`else
        data[{tag_lane, 3'b000} +: 8] <= fm_i;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_guard_fm_read_expand.sv
`default_nettype none
// Bench for guard_fm_read_expand: SRAM responders, random jobs, and a group-level expansion model.
module tb_guard_fm_read_expand;
  localparam int GAW = 10;
  localparam int FAW = 12;
  localparam int PW  = 16;
`ifdef FM_EXPAND_BITMODE_EN
  localparam bit BM_EN = 1'b1;
`else
  localparam bit BM_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           ctrl_valid, ctrl_ready, ctrl_finish;
  logic [PW-1:0]  pace_i;
  logic           bit_mode_i;
  logic [GAW-1:0] guard_base_i, guard_addr_o;
  logic [FAW-1:0] fm_base_i, fm_addr_o;
  logic           guard_rd_en, fm_rd_en;
  logic [5:0]     guard_i;
  logic [7:0]     fm_i;
  logic [47:0]    data_o;
  logic           data_o_valid, data_o_ready;

  guard_fm_read_expand #(.GUARD_ADDR_W(GAW), .FM_ADDR_W(FAW), .PACE_W(PW)) dut (
    .clk(clk), .rst(rst),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
    .pace_i(pace_i), .bit_mode_i(bit_mode_i),
    .guard_base_i(guard_base_i), .fm_base_i(fm_base_i),
    .guard_rd_en(guard_rd_en), .guard_addr_o(guard_addr_o), .guard_i(guard_i),
    .fm_rd_en(fm_rd_en), .fm_addr_o(fm_addr_o), .fm_i(fm_i),
    .data_o(data_o), .data_o_valid(data_o_valid), .data_o_ready(data_o_ready)
  );

  always #5 clk = ~clk;

  logic [5:0] gmem [1024];
  logic [7:0] fmem [4096];

  always @(posedge clk) begin
    if (guard_rd_en) guard_i <= gmem[guard_addr_o];
    if (fm_rd_en)    fm_i    <= fmem[fm_addr_o];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [47:0] exp_q[$];
  int          exp_g, exp_fm, exp_final;
  logic [47:0] last_vec;

  // Reference: walk the groups, pulling bytes from the FM image in lane 5..0 order.
  task automatic build_model(input int p, input bit bm, input int gb, input int fb);
    int          fa;
    logic [47:0] v;
    logic [5:0]  g;
    logic [7:0]  b;
    exp_q.delete();
    exp_g = 0;
    fa    = fb;
    for (int k = 0; k < p; k++) begin
      v = '0;
      if (bm) begin
        for (int j = 0; j < 3; j++) begin
          b = fmem[fa % 4096];
          fa++;
          v[(5 - 2*j)*8 +: 8] = {4'h0, b[7:4]};
          v[(4 - 2*j)*8 +: 8] = {4'h0, b[3:0]};
        end
      end else begin
        g = gmem[(gb + k) % 1024];
        exp_g++;
        for (int lane = 5; lane >= 0; lane--) begin
          if (g[lane]) begin
            v[lane*8 +: 8] = fmem[fa % 4096];
            fa++;
          end
        end
      end
      exp_q.push_back(v);
    end
    exp_fm    = fa - fb;
    exp_final = fa % 4096;
  endtask

  task automatic start_job(input int p, input bit bm, input int gb, input int fb);
    int w;
    w = 0;
    while (!ctrl_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_job", ctrl_ready, 1);
    pace_i       = PW'(p);
    bit_mode_i   = bm;
    guard_base_i = GAW'(gb);
    fm_base_i    = FAW'(fb);
    ctrl_valid   = 1'b1;
    @(negedge clk);
    ctrl_valid   = 1'b0;
  endtask

  // rmode: 0 always ready, 1 random ready, 2 hold ready low 5 cycles on first vector
  task automatic run_job(input int p, input bit bm, input int gb, input int fb, input int rmode);
    int          cyc, nfm, ng, nvec, low, fin_cyc;
    bit          done, prev_valid, prev_hs;
    logic [47:0] prev_data;
    cyc = 0; nfm = 0; ng = 0; nvec = 0; low = 0; fin_cyc = -1;
    done = 0; prev_valid = 0; prev_hs = 0; prev_data = '0;
    build_model(p, bm && BM_EN, gb, fb);
    start_job(p, bm, gb, fb);
    while (!done && cyc < 3000) begin
      case (rmode)
        0: data_o_ready = 1'b1;
        1: data_o_ready = 1'($urandom_range(0, 1));
        default: begin
          if (data_o_valid && low < 5) begin
            data_o_ready = 1'b0;
            low++;
          end else data_o_ready = 1'b1;
        end
      endcase
      ctrl_valid = ($urandom_range(0, 5) == 0) && !ctrl_finish;
      pace_i     = PW'($urandom_range(0, 9));
      fm_base_i  = FAW'($urandom);
      if (fm_rd_en) begin
        check("fm_addr", fm_addr_o, (fb + nfm) % 4096);
        nfm++;
      end
      if (guard_rd_en) begin
        check("guard_addr", guard_addr_o, (gb + ng) % 1024);
        ng++;
      end
      if (data_o_valid && (fm_rd_en || guard_rd_en)) check("read_during_emit", 1, 0);
      if (prev_valid && !prev_hs) begin
        check("valid_held", data_o_valid, 1);
        check("data_held", data_o, prev_data);
      end
      if (data_o_valid && data_o_ready) begin
        if (nvec < exp_q.size()) check("vector", data_o, exp_q[nvec]);
        else                     check("extra_vector", 1, 0);
        last_vec = data_o;
        nvec++;
      end
      if (ctrl_finish) begin
        done    = 1;
        fin_cyc = cyc;
      end
      prev_valid = data_o_valid;
      prev_hs    = data_o_valid && data_o_ready;
      prev_data  = data_o;
      @(negedge clk);
      cyc++;
    end
    ctrl_valid = 1'b0;
    check("job_done_in_time", done, 1);
    check("ready_after_finish", ctrl_ready, 1);
    check("finish_single_pulse", ctrl_finish, 0);
    check("n_vectors", nvec, exp_q.size());
    check("n_fm_reads", nfm, exp_fm);
    check("n_guard_reads", ng, exp_g);
    check("final_fm_addr", fm_addr_o, exp_final);
    if (p == 0) check("zero_pace_finish_cycle", fin_cyc, 0);
  endtask

  task automatic reset_mid_job();
    int w;
    gmem[5] = 6'h3F;
    data_o_ready = 1'b1;
    start_job(3, 0, 5, 100);
    w = 0;
    while (!fm_rd_en && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("reached_fm_rd", fm_rd_en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", ctrl_ready, 1);
    check("rst_fm_rd_en", fm_rd_en, 0);
    check("rst_guard_rd_en", guard_rd_en, 0);
    check("rst_valid", data_o_valid, 0);
    check("rst_finish", ctrl_finish, 0);
    check("rst_fm_addr", fm_addr_o, 0);
    check("rst_data", data_o, 0);
    rst = 1'b0;
  endtask

  initial begin
    int p, gb, fb;
    bit bm;
    rst = 1'b1; ctrl_valid = 1'b0; pace_i = '0; bit_mode_i = 1'b0;
    guard_base_i = '0; fm_base_i = '0; data_o_ready = 1'b1;
    guard_i = '0; fm_i = '0; last_vec = '0;
    for (int i = 0; i < 1024; i++) gmem[i] = 6'($urandom);
    for (int i = 0; i < 4096; i++) fmem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("reset_ready", ctrl_ready, 1);
    check("reset_finish", ctrl_finish, 0);
    check("reset_guard_rd_en", guard_rd_en, 0);
    check("reset_fm_rd_en", fm_rd_en, 0);
    check("reset_valid", data_o_valid, 0);
    check("reset_data", data_o, 0);
    check("reset_guard_addr", guard_addr_o, 0);
    check("reset_fm_addr", fm_addr_o, 0);
    rst = 1'b0;
    @(negedge clk);

    gmem[0] = 6'b101001;
    fmem[0] = 8'h11; fmem[1] = 8'h22; fmem[2] = 8'h33;
    run_job(1, 0, 0, 0, 0);
    check("t1_vector", last_vec, 48'h110022000033);

    gmem[10] = 6'b000000; gmem[11] = 6'b111111;
    for (int i = 0; i < 6; i++) fmem[i] = 8'(i + 1);
    run_job(2, 0, 10, 0, 0);
    check("t2_vector", last_vec, 48'h010203040506);
    check("t2_final_addr", fm_addr_o, 6);

    gmem[30] = 6'b000000;
    fmem[20] = 8'hA5; fmem[21] = 8'h3C; fmem[22] = 8'hF0;
    run_job(1, 1, 30, 20, 0);
    check("t3_vector", last_vec, BM_EN ? 48'h0A05030C0F00 : 48'h0);

    run_job(3, 0, 40, 200, 2);
    run_job(0, 0, 0, 0, 0);

    reset_mid_job();
    run_job(2, 0, 100, 3000, 1);
    run_job(3, 0, 1020, 4093, 1);

    for (int t = 0; t < 25; t++) begin
      p  = $urandom_range(0, 6);
      bm = 1'($urandom_range(0, 1));
      gb = $urandom_range(0, 1023);
      fb = ($urandom_range(0, 3) == 0) ? $urandom_range(4085, 4095) : $urandom_range(0, 4095);
      run_job(p, bm, gb, fb, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
